uart_tx: RTL and testbench

// - Serial UART transmitter; the consumer (pop side) of the TX fifo.
// - Pops bytes from a first-word-fall-through fifo and serialises them LSB-first onto tx_o: start bit, data bits, optional parity, stop bit(s).
// - Sits between the TX fifo and the FPGA TX pin; frames are sent back-to-back while the fifo is non-empty.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, line levels and helper functions used by the transmitter
// and the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Wide enough for up to 9 data bits or 2 stop bits.
    localparam int BIT_CNT_W = 4;

    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // DIV_W: baud counter width, $clog2(DIV) and never below one bit.
    function automatic int calc_div_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    // Even parity over the zero-extended word, inverted when odd is set.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..DIV-1, ticks on DIV-1, and can be held at
// zero by restart_i. Shared by the UART transmitter and receiver.
module uart_baud_cnt #(
    parameter int DIV   = 10,
    parameter int DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    output logic             tick_o,
    output logic [DIV_W-1:0] cnt_o
);

    logic [DIV_W-1:0] cnt_r;
    logic             tick_s;

    assign tick_s = (cnt_r == DIV_W'(DIV - 1));
    assign tick_o = tick_s;
    assign cnt_o  = cnt_r;

    // Counter register, wrapping at the end of every bit period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (restart_i || tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a first-word-fall-through fifo, LSB first.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_WIDTH  = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int DIV   = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int DIV_W = calc_div_w(DIV);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    if (DIV < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_tx: unsupported parameter combination");
    end

    uart_tx_state_t        state_r, state_s;
    logic [BIT_CNT_W-1:0]  bit_r, bit_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s;
    logic                  tx_r, tx_s;
    logic                  done_r, done_s;
    logic                  pop_s, load_s;
    logic                  tick_s, restart_s;
    logic [DIV_W-1:0]      cnt_s;
`ifdef UART_TX_PARITY_EN
    logic                  parity_r;
`endif

    assign restart_s = (state_r == IDLE);

    uart_baud_cnt #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_baud_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (restart_s),
        .tick_o    (tick_s),
        .cnt_o     (cnt_s)
    );

    // FSM state and bit-index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            bit_r   <= '0;
        end else begin
            state_r <= state_s;
            bit_r   <= bit_s;
        end
    end

    // Next-state logic and pop/load decisions.
    always_comb begin
        state_s = state_r;
        bit_s   = bit_r;
        pop_s   = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_i) begin
                    pop_s   = 1'b1;
                    load_s  = 1'b1;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_s = DATA;
                    bit_s   = '0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bit_r == LAST_DATA) begin
                        bit_s = '0;
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        bit_s = bit_r + BIT_CNT_W'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    state_s = STOP;
                    bit_s   = '0;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    if (bit_r == LAST_STOP) begin
                        bit_s = '0;
                        // Back-to-back frames: the next start bit follows with no idle gap.
                        if (!fifo_empty_i) begin
                            pop_s   = 1'b1;
                            load_s  = 1'b1;
                            state_s = START;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        bit_s = bit_r + BIT_CNT_W'(1);
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                bit_s   = '0;
            end
        endcase
    end

    // Datapath next values: shift register, line level and end-of-frame strobe.
    always_comb begin
        shift_s = shift_r;
        tx_s    = UART_IDLE_LVL;
        if (load_s) begin
            shift_s = fifo_data_i;
        end else if (state_r == DATA && tick_s && bit_r != LAST_DATA) begin
            shift_s = shift_r >> 1'b1;
        end else begin
            shift_s = shift_r;
        end
        case (state_s)
            START:   tx_s = UART_START_LVL;
            DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_s = parity_r;
`endif
            default: tx_s = UART_IDLE_LVL;
        endcase
        // Raised one cycle early so the registered pulse lands on the last stop cycle.
        done_s = (state_r == STOP) && (bit_r == LAST_STOP) && (cnt_s == DIV_W'(DIV - 2));
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_r <= '0;
            tx_r    <= UART_IDLE_LVL;
            done_r  <= 1'b0;
        end else begin
            shift_r <= shift_s;
            tx_r    <= tx_s;
            done_r  <= done_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is fixed at pop time so later fifo changes cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_r <= 1'b0;
        end else if (load_s) begin
            parity_r <= calc_parity(9'(fifo_data_i), PARITY_ODD[0]);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    assign fifo_pop_o = pop_s & ~rst_i;
    assign busy_o     = (state_r != IDLE) | fifo_pop_o;
    assign tx_o       = tx_r;
    assign done_o     = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 stop/even, 2 stop/odd) fed by queue fifos,
// every frame cycle compared against a bit-sequence model of the UART frame.
module tb_uart_tx;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic tb_clk = 1'b0;
    logic tb_rst = 1'b1;
    always #5 tb_clk = ~tb_clk;

    logic       empty0, empty1, pop0, pop1, tx0, tx1, busy0, busy1, done0, done1;
    logic [7:0] data0, data1;
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] exp_q[$];
    bit         pend0, pend1;
    int         vectors = 0;
    int         miscompares = 0;
    int         sel = 0;
    logic       s_tx, s_pop, s_busy, s_done;

    uart_tx #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(10_000_000), .DATA_WIDTH(8),
              .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk_i(tb_clk), .rst_i(tb_rst), .fifo_empty_i(empty0), .fifo_data_i(data0),
        .fifo_pop_o(pop0), .tx_o(tx0), .busy_o(busy0), .done_o(done0));

    uart_tx #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(10_000_000), .DATA_WIDTH(8),
              .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clk_i(tb_clk), .rst_i(tb_rst), .fifo_empty_i(empty1), .fifo_data_i(data1),
        .fifo_pop_o(pop1), .tx_o(tx1), .busy_o(busy1), .done_o(done1));

    always_comb begin
        s_tx   = (sel == 1) ? tx1   : tx0;
        s_pop  = (sel == 1) ? pop1  : pop0;
        s_busy = (sel == 1) ? busy1 : busy0;
        s_done = (sel == 1) ? done1 : done0;
    end

    function automatic void refresh();
        empty0 = (fq0.size() == 0);
        data0  = empty0 ? 8'h00 : fq0[0];
        empty1 = (fq1.size() == 0);
        data1  = empty1 ? 8'h00 : fq1[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Fifo model: a pop seen mid-cycle retires the head one cycle later.
    always @(negedge tb_clk) begin
        if (pend0) void'(fq0.pop_front());
        if (pend1) void'(fq1.pop_front());
        chk("pop_while_empty0", {31'd0, pop0 & empty0}, 32'd0);
        chk("pop_while_empty1", {31'd0, pop1 & empty1}, 32'd0);
        pend0 = (pop0 === 1'b1);
        pend1 = (pop1 === 1'b1);
        refresh();
    end

    // Line level at bit slot idx of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx, input int odd);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR == 1 && idx == 9) return 1'(($countones(b) + odd) % 2);
        return 1'b1;
    endfunction

    task automatic push(input int s, input logic [7:0] b);
        if (s == 1) fq1.push_back(b);
        else        fq0.push_back(b);
        exp_q.push_back(b);
        refresh();
    endtask

    // Checks nfr consecutive frames starting from the next pop of instance s.
    task automatic run_frames(input int s, input int nfr);
        int stop, odd, len, waited, f, pos;
        logic [7:0] fb[$];
        stop   = (s == 1) ? 2 : 1;
        odd    = (s == 1) ? 1 : 0;
        len    = (1 + 8 + PAR + stop) * DIV;
        waited = 0;
        sel    = s;
        for (int i = 0; i < nfr; i++) fb.push_back(exp_q.pop_front());
        do begin
            @(negedge tb_clk);
            waited++;
        end while (s_pop !== 1'b1 && waited < 50);
        chk($sformatf("pop_start dut%0d", s), {31'd0, s_pop}, 32'd1);
        chk("busy_at_pop", {31'd0, s_busy}, 32'd1);
        chk("tx_at_pop", {31'd0, s_tx}, 32'd1);
        for (int k = 1; k <= nfr * len; k++) begin
            @(negedge tb_clk);
            f   = (k - 1) / len;
            pos = (k - 1) % len;
            chk($sformatf("tx f%0d pos%0d", f, pos), {31'd0, s_tx},
                {31'd0, exp_bit(fb[f], pos / DIV, odd)});
            chk($sformatf("done f%0d pos%0d", f, pos), {31'd0, s_done},
                {31'd0, pos == len - 1});
            chk($sformatf("pop f%0d pos%0d", f, pos), {31'd0, s_pop},
                {31'd0, (pos == len - 1) && (f < nfr - 1)});
            chk($sformatf("busy f%0d pos%0d", f, pos), {31'd0, s_busy}, 32'd1);
        end
        @(negedge tb_clk);
        chk("busy_after", {31'd0, s_busy}, 32'd0);
        chk("tx_after", {31'd0, s_tx}, 32'd1);
        chk("done_after", {31'd0, s_done}, 32'd0);
        chk("pop_after", {31'd0, s_pop}, 32'd0);
    endtask

    initial begin
        int n, waited;
        refresh();
        repeat (5) @(posedge tb_clk);
        #1 tb_rst = 1'b0;

        // Idle after reset with empty fifos.
        for (int i = 0; i < 100; i++) begin
            @(negedge tb_clk);
            chk("rst_tx0", {31'd0, tx0}, 32'd1);
            chk("rst_busy0", {31'd0, busy0}, 32'd0);
            chk("rst_done0", {31'd0, done0}, 32'd0);
            chk("rst_tx1", {31'd0, tx1}, 32'd1);
            chk("rst_busy1", {31'd0, busy1}, 32'd0);
        end

        @(posedge tb_clk); #1 push(0, 8'hA5);
        run_frames(0, 1);

        @(posedge tb_clk); #1;
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55); push(0, 8'h3C);
        run_frames(0, 4);

        @(posedge tb_clk); #1;
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) push(0, 8'($urandom));
        run_frames(0, n);

        @(posedge tb_clk); #1 push(1, 8'h07);
        run_frames(1, 1);
        @(posedge tb_clk); #1 push(1, 8'hC3);
        run_frames(1, 1);
        @(posedge tb_clk); #1;
        push(1, 8'($urandom)); push(1, 8'($urandom));
        run_frames(1, 2);

        // Reset during data bit 3 of 0x81; 0x5A must follow intact.
        sel = 0;
        @(posedge tb_clk); #1;
        push(0, 8'h81); push(0, 8'h5A);
        waited = 0;
        do begin
            @(negedge tb_clk);
            waited++;
        end while (pop0 !== 1'b1 && waited < 50);
        chk("abort_pop", {31'd0, pop0}, 32'd1);
        repeat (45) @(negedge tb_clk);
        chk("abort_bit3", {31'd0, tx0}, 32'd0);
        tb_rst = 1'b1;
        @(negedge tb_clk);
        chk("abort_tx", {31'd0, tx0}, 32'd1);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_nopop", {31'd0, pop0}, 32'd0);
        chk("abort_fifo_left", 32'(fq0.size()), 32'd1);
        @(posedge tb_clk); #1 tb_rst = 1'b0;
        void'(exp_q.pop_front());
        run_frames(0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
